// File: rtl/fp16_op_seq.sv
// Sequencer for a two-operand FP16 operation: unpacks A then B through a shared
// load unit, starts the execute unit and returns its result (or NaN on timeout).
module fp16_op_seq #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        ld_enable,
    output logic [15:0] ld_data,
    input  logic        ld_valid,
    input  logic        ld_sign,
    input  logic [4:0]  ld_exp,
    input  logic [9:0]  ld_mant,
    output logic        a_sign,
    output logic [4:0]  a_exp,
    output logic [9:0]  a_mant,
    output logic        b_sign,
    output logic [4:0]  b_exp,
    output logic [9:0]  b_mant,
    output logic        exe_start,
    output logic [1:0]  exe_op,
    input  logic        exe_done,
    input  logic [15:0] exe_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_GAP,
        S_LOAD_B,
        S_EXEC,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [15:0] NAN_WORD = 16'h7E00;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [15:0] opb_reg, opb_next;
    logic [1:0]  op_reg, op_next;
    logic [15:0] ld_data_reg, ld_data_next;
    logic [15:0] a_reg, a_next;
    logic [15:0] b_reg, b_next;
    logic [15:0] resp_data_reg, resp_data_next;
    logic        resp_err_reg, resp_err_next;
    logic        expired;

    assign expired = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 8'd0;
            opb_reg       <= 16'd0;
            op_reg        <= 2'd0;
            ld_data_reg   <= 16'd0;
            a_reg         <= 16'd0;
            b_reg         <= 16'd0;
            resp_data_reg <= 16'd0;
            resp_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            opb_reg       <= opb_next;
            op_reg        <= op_next;
            ld_data_reg   <= ld_data_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            resp_data_reg <= resp_data_next;
            resp_err_reg  <= resp_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        opb_next       = opb_reg;
        op_next        = op_reg;
        ld_data_next   = ld_data_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        resp_data_next = resp_data_reg;
        resp_err_next  = resp_err_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    // A goes straight into ld_data; only B needs its own copy.
                    ld_data_next = req_a;
                    opb_next     = req_b;
                    op_next      = req_op;
                    cnt_next     = 8'd0;
                    state_next   = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (ld_valid) begin
                    a_next     = {ld_sign, ld_exp, ld_mant};
                    state_next = S_GAP;
                end else if (expired) begin
                    resp_data_next = NAN_WORD;
                    resp_err_next  = 1'b1;
                    state_next     = S_RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_GAP: begin
                ld_data_next = opb_reg;
                cnt_next     = 8'd0;
                state_next   = S_LOAD_B;
            end
            S_LOAD_B: begin
                if (ld_valid) begin
                    b_next     = {ld_sign, ld_exp, ld_mant};
                    state_next = S_EXEC;
                end else if (expired) begin
                    resp_data_next = NAN_WORD;
                    resp_err_next  = 1'b1;
                    state_next     = S_RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_EXEC: begin
                cnt_next   = 8'd0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (exe_done) begin
                    resp_data_next = exe_result;
                    resp_err_next  = 1'b0;
                    state_next     = S_RESP;
                end else if (expired) begin
                    resp_data_next = NAN_WORD;
                    resp_err_next  = 1'b1;
                    state_next     = S_RESP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign req_ready  = (state_reg == S_IDLE);
    assign ld_enable  = (state_reg == S_LOAD_A) || (state_reg == S_LOAD_B);
    assign exe_start  = (state_reg == S_EXEC);
    assign resp_valid = (state_reg == S_RESP);

    assign ld_data   = ld_data_reg;
    assign exe_op    = op_reg;
    assign resp_data = resp_data_reg;
    assign resp_err  = resp_err_reg;
    assign a_sign    = a_reg[15];
    assign a_exp     = a_reg[14:10];
    assign a_mant    = a_reg[9:0];
    assign b_sign    = b_reg[15];
    assign b_exp     = b_reg[14:10];
    assign b_mant    = b_reg[9:0];

endmodule

// File: tb/tb_fp16_op_seq.sv
// Bench for fp16_op_seq: scheduled load/execute-unit behaviour per transaction,
// per-cycle output comparison, plus directed literal checks of the key scenarios.
module tb_fp16_op_seq;

    localparam int TO    = 4;
    localparam int NEVER = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        ld_enable, ld_valid, ld_sign;
    logic [15:0] ld_data;
    logic [4:0]  ld_exp;
    logic [9:0]  ld_mant;
    logic        a_sign, b_sign;
    logic [4:0]  a_exp, b_exp;
    logic [9:0]  a_mant, b_mant;
    logic        exe_start, exe_done;
    logic [1:0]  exe_op;
    logic [15:0] exe_result;
    logic        resp_valid, resp_ready, resp_err;
    logic [15:0] resp_data;

    always #5 clk = ~clk;

    fp16_op_seq #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .ld_enable(ld_enable), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_sign(ld_sign), .ld_exp(ld_exp), .ld_mant(ld_mant),
        .a_sign(a_sign), .a_exp(a_exp), .a_mant(a_mant),
        .b_sign(b_sign), .b_exp(b_exp), .b_mant(b_mant),
        .exe_start(exe_start), .exe_op(exe_op),
        .exe_done(exe_done), .exe_result(exe_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int acc_cyc = 0;
    int dut_resp_cyc = 0;
    int start_cnt = 0;
    int txn_no = 0;
    logic [4:0] en_wave = 5'd0;
    logic prev_rv = 1'b0;
    logic chk_on = 1'b0;

    // Expected outputs for the current cycle, maintained by the stimulus model.
    logic        e_req_ready, e_ld_en, e_exe_start, e_resp_valid, e_resp_err;
    logic [15:0] e_ld_data, e_a, e_b, e_resp_data;
    logic [1:0]  e_exe_op;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready",  16'(req_ready),  16'(e_req_ready));
            chk("ld_enable",  16'(ld_enable),  16'(e_ld_en));
            chk("ld_data",    ld_data,         e_ld_data);
            chk("a_fields",   {a_sign, a_exp, a_mant}, e_a);
            chk("b_fields",   {b_sign, b_exp, b_mant}, e_b);
            chk("exe_start",  16'(exe_start),  16'(e_exe_start));
            chk("exe_op",     16'(exe_op),     16'(e_exe_op));
            chk("resp_valid", 16'(resp_valid), 16'(e_resp_valid));
            chk("resp_data",  resp_data,       e_resp_data);
            chk("resp_err",   16'(resp_err),   16'(e_resp_err));
        end
        if (exe_start) start_cnt++;
        if (resp_valid && !prev_rv) dut_resp_cyc = cyc_cnt;
        prev_rv = resp_valid;
        if (cyc_cnt - acc_cyc >= 1 && cyc_cnt - acc_cyc <= 5)
            en_wave[3'(5 - (cyc_cnt - acc_cyc))] = ld_enable;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_expect();
        e_req_ready = 1'b1; e_ld_en = 1'b0; e_exe_start = 1'b0; e_resp_valid = 1'b0;
        e_resp_err = 1'b0; e_ld_data = 16'd0; e_a = 16'd0; e_b = 16'd0;
        e_exe_op = 2'd0; e_resp_data = 16'd0;
    endtask

    task automatic junk();
        exe_done = 1'($urandom); exe_result = 16'($urandom);
        resp_ready = 1'($urandom); req_valid = 1'($urandom);
        req_a = 16'($urandom); req_b = 16'($urandom); req_op = 2'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0; ld_valid = 1'($urandom); exe_done = 1'($urandom);
            resp_ready = 1'($urandom);
            tick();
        end
    endtask

    // Load unit answers in cycle d of the LOAD state (NEVER = silent).
    task automatic load(input logic [15:0] w, input int d, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < TO; n++) begin
            junk();
            e_ld_en = 1'b1;
            ld_valid = (n == d);
            {ld_sign, ld_exp, ld_mant} = (n == d) ? w : 16'($urandom);
            tick();
            if (n == d) begin
                ok = 1'b1;
                break;
            end
        end
        e_ld_en = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                       input int da, input int db, input int de, input int rw,
                       input logic [15:0] res, input int rst_wait);
        logic ok;
        txn_no++;
        junk();
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op; ld_valid = 1'($urandom);
        e_req_ready = 1'b1; e_ld_en = 1'b0; e_exe_start = 1'b0; e_resp_valid = 1'b0;
        acc_cyc = cyc_cnt;
        tick();
        e_req_ready = 1'b0; e_ld_data = a; e_exe_op = op;
        load(a, da, ok);
        if (ok) begin
            e_a = a;
            junk(); ld_valid = 1'($urandom);
            tick();
            e_ld_data = b;
            load(b, db, ok);
            if (ok) begin
                e_b = b;
                junk(); ld_valid = 1'($urandom);
                e_exe_start = 1'b1;
                tick();
                e_exe_start = 1'b0;
                ok = 1'b0;
                for (int n = 0; n < TO; n++) begin
                    junk(); ld_valid = 1'($urandom);
                    if (n == rst_wait) begin
                        exe_done = 1'b0;
                        rst = 1'b1;
                        tick();
                        rst = 1'b0;
                        reset_expect();
                        req_valid = 1'b0; exe_done = 1'b0; ld_valid = 1'b0;
                        $display("txn %0d a=%h b=%h op=%0d aborted by reset in WAIT", txn_no, a, b, op);
                        return;
                    end
                    exe_done = (n == de);
                    exe_result = (n == de) ? res : 16'($urandom);
                    tick();
                    if (n == de) begin
                        ok = 1'b1;
                        e_resp_data = res;
                        e_resp_err = 1'b0;
                        break;
                    end
                end
            end
        end
        if (!ok) begin
            e_resp_data = 16'h7E00;
            e_resp_err = 1'b1;
        end
        e_resp_valid = 1'b1;
        for (int k = 0; k <= rw; k++) begin
            junk(); ld_valid = 1'($urandom);
            resp_ready = (k == rw);
            tick();
        end
        e_resp_valid = 1'b0;
        e_req_ready = 1'b1;
        req_valid = 1'b0; resp_ready = 1'b0; exe_done = 1'b0; ld_valid = 1'b0;
        $display("txn %0d a=%h b=%h op=%0d da=%0d db=%0d de=%0d rw=%0d -> data=%h err=%0d",
                 txn_no, a, b, op, da, db, de, rw, e_resp_data, e_resp_err);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_a = 16'd0; req_b = 16'd0;
        ld_valid = 1'b0; ld_sign = 1'b0; ld_exp = 5'd0; ld_mant = 10'd0;
        exe_done = 1'b0; exe_result = 16'd0; resp_ready = 1'b0;
        tick();
        tick();
        reset_expect();
        rst = 1'b0;
        chk("rst_req_ready", 16'(req_ready), 16'd1);
        chk("rst_ld_enable", 16'(ld_enable), 16'd0);
        chk("rst_resp_data", resp_data, 16'd0);
        chk_on = 1'b1;

        // Nominal transaction
        start_cnt = 0;
        txn(16'h3C00, 16'hC000, 2'd2, 1, 1, 0, 0, 16'hBC00, -1);
        chk("nom_latency", 16'(dut_resp_cyc - acc_cyc), 16'd8);
        chk("nom_a", {a_sign, a_exp, a_mant}, {1'b0, 5'd15, 10'd0});
        chk("nom_b", {b_sign, b_exp, b_mant}, {1'b1, 5'd16, 10'd0});
        chk("nom_op", 16'(exe_op), 16'd2);
        chk("nom_starts", 16'(start_cnt), 16'd1);
        chk("nom_data", resp_data, 16'hBC00);
        chk("nom_err", 16'(resp_err), 16'd0);
        chk("nom_en_wave", 16'(en_wave), 16'b11011);
        idle(1);

        // Execute-unit timeout: 4 WAIT cycles then NaN
        start_cnt = 0;
        txn(16'h4000, 16'h3800, 2'd1, 1, 1, NEVER, 0, 16'h0000, -1);
        chk("exto_latency", 16'(dut_resp_cyc - acc_cyc), 16'd11);
        chk("exto_data", resp_data, 16'h7E00);
        chk("exto_err", 16'(resp_err), 16'd1);
        chk("exto_starts", 16'(start_cnt), 16'd1);

        // Load timeout on A
        start_cnt = 0;
        txn(16'h1234, 16'h5678, 2'd3, NEVER, 1, 0, 0, 16'h0000, -1);
        chk("ldto_latency", 16'(dut_resp_cyc - acc_cyc), 16'd5);
        chk("ldto_err", 16'(resp_err), 16'd1);
        chk("ldto_starts", 16'(start_cnt), 16'd0);

        // Pulses arriving exactly at the last allowed cycle win over timeout
        txn(16'h3555, 16'hB2AA, 2'd0, TO - 1, TO - 1, TO - 1, 0, 16'h4321, -1);
        chk("edge_data", resp_data, 16'h4321);
        chk("edge_err", 16'(resp_err), 16'd0);

        // Backpressure
        txn(16'h3C00, 16'hC000, 2'd2, 1, 1, 0, 5, 16'h2468, -1);
        chk("bp_data", resp_data, 16'h2468);

        // Reset in WAIT, then a clean nominal transaction
        txn(16'h7BFF, 16'h0400, 2'd1, 1, 1, NEVER, 0, 16'h0000, 1);
        chk("rst_wait_resp_valid", 16'(resp_valid), 16'd0);
        txn(16'h3C00, 16'hC000, 2'd2, 1, 1, 0, 0, 16'hBC00, -1);
        chk("post_rst_latency", 16'(dut_resp_cyc - acc_cyc), 16'd8);
        chk("post_rst_data", resp_data, 16'hBC00);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int da, db, de, rwv, rstw;
            da   = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
            db   = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
            de   = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
            rwv  = int'($urandom_range(0, 3));
            rstw = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, TO - 1)) : -1;
            txn(16'($urandom), 16'($urandom), 2'($urandom), da, db, de, rwv,
                16'($urandom), rstw);
            idle(int'($urandom_range(0, 2)));
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp16_op_seq.md
FP16_OP_SEQ -- requirements
Module: fp16_op_seq

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles spent waiting in any LOAD or WAIT state (legal 2..255).
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  high only in IDLE.
REQ-006 req_op  in  2  operation code, passed through to exe_op.
REQ-007 req_a, req_b  in  16  FP16 operands A and B.
REQ-008 ld_enable  out  1  enable to the FP16 unpack (load) unit.
REQ-009 ld_data  out  16  word presented to the load unit.
REQ-010 ld_valid  in  1  one-cycle pulse from the load unit: fields captured.
REQ-011 ld_sign  in  1, ld_exp  in  5, ld_mant  in  10  unpacked fields from the load unit.
REQ-012 a_sign/a_exp/a_mant, b_sign/b_exp/b_mant  out  1/5/10 each  registered operand fields.
REQ-013 exe_start  out  1, exe_op  out  2  one-cycle start to the execute unit, with registered opcode.
REQ-014 exe_done  in  1, exe_result  in  16  execute-unit completion and result.
REQ-015 resp_valid  out  1, resp_ready  in  1, resp_data  out  16, resp_err  out  1  response handshake.

Function
REQ-016 FSM states: IDLE, LOAD_A, GAP, LOAD_B, EXEC, WAIT, RESP; all outputs are registered or decoded from registered state only.
REQ-017 IDLE: req_ready=1; on req_valid, latch req_a/req_b/req_op, go LOAD_A; the latched copies are the only values used afterwards.
REQ-018 LOAD_A: ld_enable=1, ld_data=latched A; on ld_valid capture ld_sign/exp/mant into a_* and go GAP.
REQ-019 GAP: ld_enable=0 for exactly one cycle, so the load unit sees a fresh rising enable; then go LOAD_B.
REQ-020 LOAD_B: as LOAD_A, using latched B and b_*; on ld_valid go EXEC.
REQ-021 ld_enable is high only in LOAD_A/LOAD_B; ld_data holds its last value elsewhere.
REQ-022 EXEC: exe_start=1 for exactly one cycle; go WAIT. exe_op holds the latched opcode from acceptance until IDLE.
REQ-023 WAIT: on exe_done, resp_data<=exe_result, resp_err<=0, go RESP; exe_done in any other state is ignored.
REQ-024 Timeout: an 8-bit counter clears on entry to LOAD_A, LOAD_B and WAIT and increments each cycle spent there without the awaited pulse.
REQ-025 Timeout expiry: counter == TIMEOUT-1 with no pulse -> resp_data<=16'h7E00 (canonical NaN), resp_err<=1, go RESP; a_*/b_* not yet captured keep their prior values.
REQ-026 If the awaited pulse and timeout expiry coincide, the pulse wins (normal completion).
REQ-027 ld_valid outside LOAD_A/LOAD_B is ignored.
REQ-028 RESP: resp_valid=1, resp_data/resp_err stable until resp_ready; on resp_valid&resp_ready go IDLE; next request is accepted no earlier than the following cycle.
REQ-029 Nominal latency with a conforming load unit (ld_valid one cycle after enable) and exe_done in the first WAIT cycle: request accepted at edge 0 -> resp_valid high in cycle 8.

Reset
REQ-030 On rst: state=IDLE, counter=0, req_ready=1 in the following cycle.
REQ-031 On rst: ld_enable=0, exe_start=0, resp_valid=0, resp_err=0.
REQ-032 On rst: ld_data, a_*, b_*, exe_op, resp_data all cleared to 0.
REQ-033 Reset mid-operation (any state) abandons the transaction with no response; ld_enable is low in the first cycle after the reset edge.

Verification
REQ-034 Nominal: A=16'h3C00, B=16'hC000, op=2, exe_done+result 16'hBC00 in the first WAIT cycle -> a=(0,15,0), b=(1,16,0), exe_op=2, single exe_start pulse, resp_valid in cycle 8, resp_data=16'hBC00, resp_err=0.
REQ-035 Enable gap: ld_enable waveform is 1,1,0,1,1 over cycles 1-5, and the load unit produces two distinct ld_valid pulses.
REQ-036 Exe timeout (TIMEOUT=4): exe_done never asserted -> exactly 4 WAIT cycles, then resp_data=16'h7E00, resp_err=1.
REQ-037 Load timeout: ld_valid held low during LOAD_A -> after TIMEOUT cycles: RESP with err=1, exe_start never pulses.
REQ-038 Backpressure: resp_ready low for 5 cycles -> resp_valid/resp_data stable throughout, req_ready=0, a new req_valid is not accepted; exe_done pulse during RESP is ignored.
REQ-039 Reset in WAIT, then a new request -> no stale response; second transaction completes with nominal timing.
